cnt_capture_disp: RTL and testbench

CNT_CAPTURE_DISP -- requirements
Module: cnt_capture_disp

---
 rtl/cnt_capture_disp.sv | 107 ++++++++++
 tb/tb_cnt_capture_disp.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cnt_capture_disp.sv
// Extends an upstream 4-bit counter with a 4-bit carry counter, captures the
// 8-bit value on demand, and scans it onto a two-digit 7-segment display.
module cnt_capture_disp #(
  parameter int DIV_W = 4
) (
  input  logic       CLK,
  input  logic       CLR_L,
  input  logic       QA,
  input  logic       QB,
  input  logic       QC,
  input  logic       QD,
  input  logic       RCO,
  input  logic       CAP,
  output logic       VALID,
  output logic       OVF,
  output logic [7:0] CAPV,
  output logic [1:0] DIG_L,
  output logic [6:0] SEG
);

  logic             rco_q, rco_d;
  logic             cap_q, cap_d;
  logic [3:0]       ext_q, ext_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       capv_q, capv_d;
  logic             valid_q, valid_d;
  logic [DIV_W:0]   scan_q, scan_d;
  logic             rco_edge, cap_edge;
  logic [3:0]       nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign rco_edge = RCO & ~rco_q;
  assign cap_edge = CAP & ~cap_q;

  // Capture samples EXT before this cycle's increment lands.
  always_comb begin
    rco_d   = RCO;
    cap_d   = CAP;
    ext_d   = ext_q;
    ovf_d   = ovf_q;
    capv_d  = capv_q;
    valid_d = valid_q;
    scan_d  = scan_q + (DIV_W+1)'(1);
    if (cap_edge) begin
      capv_d  = {ext_q, QD, QC, QB, QA};
      valid_d = 1'b1;
    end
    if (rco_edge) begin
      ext_d = ext_q + 4'd1;
      if (ext_q == 4'hF) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_L) begin
      rco_q   <= 1'b0;
      cap_q   <= 1'b0;
      ext_q   <= 4'd0;
      ovf_q   <= 1'b0;
      capv_q  <= 8'd0;
      valid_q <= 1'b0;
      scan_q  <= '0;
    end else begin
      rco_q   <= rco_d;
      cap_q   <= cap_d;
      ext_q   <= ext_d;
      ovf_q   <= ovf_d;
      capv_q  <= capv_d;
      valid_q <= valid_d;
      scan_q  <= scan_d;
    end
  end

  // Display decode reads registered state only.
  always_comb begin
    nib   = scan_q[DIV_W] ? capv_q[7:4] : capv_q[3:0];
    DIG_L = scan_q[DIV_W] ? 2'b01 : 2'b10;
    SEG   = valid_q ? hex7(nib) : 7'h7F;
  end

  assign VALID = valid_q;
  assign OVF   = ovf_q;
  assign CAPV  = capv_q;

endmodule

// File: tb/tb_cnt_capture_disp.sv
// Randomized and directed bench for cnt_capture_disp against a cycle-level
// behavioural model of the capture/extension/display rules.
module tb_cnt_capture_disp;
  localparam int DIV_W = 4;
  localparam int HALF  = 1 << DIV_W;

  logic       CLK = 1'b0;
  logic       CLR_L = 1'b0;
  logic       QA = 1'b0, QB = 1'b0, QC = 1'b0, QD = 1'b0;
  logic       RCO = 1'b0, CAP = 1'b0;
  logic       VALID, OVF;
  logic [7:0] CAPV;
  logic [1:0] DIG_L;
  logic [6:0] SEG;

  int tests = 0;
  int fails = 0;

  cnt_capture_disp #(.DIV_W(DIV_W)) dut (
    .CLK(CLK), .CLR_L(CLR_L), .QA(QA), .QB(QB), .QC(QC), .QD(QD),
    .RCO(RCO), .CAP(CAP), .VALID(VALID), .OVF(OVF), .CAPV(CAPV),
    .DIG_L(DIG_L), .SEG(SEG)
  );

  always #5 CLK = ~CLK;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Behavioural model: integer state advanced once per clock edge.
  int  m_ext = 0, m_capv = 0, m_cyc = 0;
  bit  m_ovf = 0, m_valid = 0, m_prev_rco = 0, m_prev_cap = 0, m_ready = 0;

  always @(posedge CLK) begin
    int q;
    q = {QD, QC, QB, QA};
    if (!CLR_L) begin
      m_ext = 0; m_capv = 0; m_cyc = 0; m_ovf = 0; m_valid = 0;
      m_prev_rco = 0; m_prev_cap = 0; m_ready = 1;
    end else begin
      if (CAP && !m_prev_cap) begin
        m_capv  = m_ext * 16 + q;
        m_valid = 1;
      end
      if (RCO && !m_prev_rco) begin
        if (m_ext == 15) m_ovf = 1;
        m_ext = (m_ext + 1) % 16;
      end
      m_prev_rco = RCO;
      m_prev_cap = CAP;
      m_cyc++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (m_ready) begin
      int hi, dig;
      hi  = (m_cyc / HALF) % 2;
      dig = hi ? (m_capv / 16) : (m_capv % 16);
      chk("VALID", int'(VALID), int'(m_valid));
      chk("OVF", int'(OVF), int'(m_ovf));
      chk("CAPV", int'(CAPV), m_capv);
      chk("DIG_L", int'(DIG_L), hi ? 1 : 2);
      chk("SEG", int'(SEG), m_valid ? int'(seg_tbl[dig]) : 'h7F);
    end
  end

  task automatic step(input bit clr, input int q, input bit rco, input bit cap);
    CLR_L = clr;
    {QD, QC, QB, QA} = q[3:0];
    RCO = rco;
    CAP = cap;
    @(negedge CLK);
  endtask

  task automatic rst2();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic rco_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 1, 0);
      step(1, 0, 0, 0);
    end
  endtask

  initial begin
    // Reset then idle scanning.
    rst2();
    chk("rst_DIG_L", int'(DIG_L), 2);
    chk("rst_SEG", int'(SEG), 'h7F);
    chk("rst_VALID", int'(VALID), 0);
    chk("rst_OVF", int'(OVF), 0);
    for (int i = 0; i < HALF; i++) step(1, 0, 0, 0);
    chk("scan_hi", int'(DIG_L), 1);
    chk("idle_SEG", int'(SEG), 'h7F);
    for (int i = 0; i < HALF; i++) step(1, 0, 0, 0);
    chk("scan_lo", int'(DIG_L), 2);

    // Three carries, Q=5, capture.
    rst2();
    rco_pulses(3);
    step(1, 5, 0, 1);
    step(1, 5, 0, 0);
    chk("cap35", int'(CAPV), 'h35);
    chk("model_cap35", m_capv, 'h35);
    chk("cap35_valid", int'(VALID), 1);
    for (int i = 0; i < 2 * HALF; i++) begin
      step(1, 0, 0, 0);
      if (i == 3 || i == HALF + 3)
        chk("seg35", int'(SEG), (DIG_L == 2'b10) ? 'h12 : 'h30);
    end

    // RCO held high counts once.
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0);
    step(1, 9, 0, 1);
    step(1, 9, 0, 0);
    chk("rco_held", int'(CAPV), 'h49);

    // Sixteen carries wrap EXT and set OVF; reset clears it.
    rst2();
    rco_pulses(16);
    chk("ovf_set", int'(OVF), 1);
    step(1, 2, 0, 1);
    step(1, 2, 0, 0);
    chk("ext_wrap", int'(CAPV), 'h02);
    rst2();
    chk("ovf_clr", int'(OVF), 0);

    // Simultaneous capture and carry.
    rco_pulses(7);
    step(1, 15, 1, 1);
    step(1, 15, 0, 0);
    chk("cap7F", int'(CAPV), 'h7F);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("ext8", int'(CAPV), 'h80);

    // Reset wins over a capture edge; CAP already high after reset is an edge.
    step(0, 3, 1, 1);
    chk("rst_cap_capv", int'(CAPV), 0);
    chk("rst_cap_valid", int'(VALID), 0);
    step(1, 6, 0, 1);
    chk("post_rst_cap", int'(CAPV), 'h06);
    step(1, 6, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 99) != 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
